// File: rtl/fifo_drain_ctrl.sv
// Read-clock-domain drain controller for fifo1: pops a fixed burst into a local buffer,
// replays it on a valid/ready stream and reports a modular checksum.
`timescale 1ns / 1ps

module fifo_drain_ctrl #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned BURST = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] checksum
);

  localparam int unsigned IdxW  = $clog2(BURST + 1);
  localparam int unsigned AddrW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [IdxW-1:0] BurstCnt = IdxW'(BURST);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(BURST - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e           state_q;
  logic [IdxW-1:0]  wr_idx_q;
  logic [IdxW-1:0]  rd_idx_q;
  logic [IdxW-1:0]  rd_next;
  logic [DSIZE-1:0] mem_q [BURST];
  logic [DSIZE-1:0] out_data_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [DSIZE-1:0] checksum_q;

  // Pop only on the registered empty flag; no dependence on start or out_ready.
  assign rinc    = (state_q == StFill) && !rempty && (wr_idx_q < BurstCnt);
  assign rd_next = rd_idx_q + IdxW'(1);

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (rinc) begin
      mem_q[wr_idx_q[AddrW-1:0]] <= rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StFill;
            busy_q     <= 1'b1;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            checksum_q <= '0;
          end
        end
        StFill: begin
          if (rinc) begin
            checksum_q <= checksum_q + rdata;
            wr_idx_q   <= wr_idx_q + IdxW'(1);
            // Word 0 was captured on an earlier edge since BURST >= 2.
            if (wr_idx_q == LastIdx) begin
              state_q     <= StDrain;
              out_data_q  <= mem_q[0];
              out_valid_q <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready) begin
            if (rd_idx_q == LastIdx) begin
              state_q     <= StDone;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              rd_idx_q   <= rd_next;
              out_data_q <= mem_q[rd_next[AddrW-1:0]];
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural show-ahead FIFO model, output monitor and a
// scoreboard of expected words per transaction.
`timescale 1ns / 1ps

module tb_fifo_drain_ctrl;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned BURST = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic [DSIZE-1:0] rdata = '0;
  logic             rempty = 1'b1;
  logic             rinc;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [DSIZE-1:0] checksum;

  fifo_drain_ctrl #(.DSIZE(DSIZE), .BURST(BURST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // FIFO model: words written by tests land in wr_log and become visible one edge later.
  logic [DSIZE-1:0] wr_log[$];
  logic [DSIZE-1:0] fifo_q[$];
  int               wr_taken = 0;
  int               pop_cyc_q[$];
  int               empty_pops = 0;
  int               cyc = 0;

  always @(posedge clk) begin
    if (rinc) begin
      if (rempty || fifo_q.size() == 0) empty_pops++;
      else void'(fifo_q.pop_front());
      pop_cyc_q.push_back(cyc);
    end
    while (wr_taken < wr_log.size()) begin
      fifo_q.push_back(wr_log[wr_taken]);
      wr_taken++;
    end
    rempty <= (fifo_q.size() == 0);
    if (fifo_q.size() > 0) rdata <= fifo_q[0];
    cyc++;
  end

  // Output monitor, sampled mid-cycle.
  logic [DSIZE-1:0] got_q[$];
  int               acc_cyc_q[$];
  int               done_cyc_q[$];
  logic             done_busy_q[$];
  int               vrise_q[$];
  int               stab_err = 0;
  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;
  logic [DSIZE-1:0] prev_d = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r && (!out_valid || out_data !== prev_d)) stab_err++;
      if (out_valid && !prev_v) vrise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        acc_cyc_q.push_back(cyc);
      end
      if (done) begin
        done_cyc_q.push_back(cyc);
        done_busy_q.push_back(busy);
      end
    end
    prev_v = out_valid;
    prev_r = out_ready;
    prev_d = out_data;
  end

  logic [DSIZE-1:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int db, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done_cyc_q.size() > db) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp += 6;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    if (rinc !== 1'b0) begin n_err++; $display("FAIL reset_rinc got %b want 0", rinc); end
    if (checksum !== 8'h00) begin n_err++; $display("FAIL reset_checksum got %h want 00", checksum); end
    if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int pb, gb, db, vb, s;
    bit ok;
    logic [DSIZE-1:0] sum, e, a;
    exp_q.delete();
    sum = '0;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_log.push_back(8'(i));
      exp_q.push_back(8'(i));
      sum += 8'(i);
    end
    tick();
    tick();
    pb = pop_cyc_q.size(); gb = got_q.size(); db = done_cyc_q.size(); vb = vrise_q.size();
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    wait_done(db, 200, ok);
    tick();
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL b2b_timeout got no done want done"); end
    n_cmp++;
    if (pop_cyc_q.size() - pb != 16)
      begin n_err++; $display("FAIL b2b_pops got %0d want 16", pop_cyc_q.size() - pb); end
    if (pop_cyc_q.size() >= pb + 16) begin
      n_cmp += 2;
      if (pop_cyc_q[pb] != s + 1)
        begin n_err++; $display("FAIL b2b_first_pop got %0d want %0d", pop_cyc_q[pb], s + 1); end
      if (pop_cyc_q[pb+15] != s + 16)
        begin n_err++; $display("FAIL b2b_last_pop got %0d want %0d", pop_cyc_q[pb+15], s + 16); end
    end
    n_cmp++;
    if (vrise_q.size() <= vb || vrise_q[vb] != s + 17)
      begin n_err++; $display("FAIL b2b_valid_rise got %0d want %0d", (vrise_q.size() > vb) ? vrise_q[vb] : -1, s + 17); end
    n_cmp += 2;
    if (done_cyc_q.size() != db + 1 || done_cyc_q[db] != s + 33)
      begin n_err++; $display("FAIL b2b_done_cycle got %0d want %0d", (done_cyc_q.size() > db) ? done_cyc_q[db] : -1, s + 33); end
    if (done_busy_q.size() <= db || done_busy_q[db] !== 1'b0)
      begin n_err++; $display("FAIL b2b_busy_at_done got %b want 0", (done_busy_q.size() > db) ? done_busy_q[db] : 1'bx); end
    n_cmp++;
    if (checksum !== sum || checksum !== 8'h88)
      begin n_err++; $display("FAIL b2b_checksum got %h want 88", checksum); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      a = (gb + i < got_q.size()) ? got_q[gb+i] : 'x;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_starved();
    int pb, gb, db, ep;
    bit ok;
    logic [DSIZE-1:0] sum, e, a;
    exp_q.delete();
    sum = '0;
    out_ready = 1'b1;
    pb = pop_cyc_q.size(); gb = got_q.size(); db = done_cyc_q.size(); ep = empty_pops;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr_log.push_back(8'(8'hA0 + i));
      exp_q.push_back(8'(8'hA0 + i));
      sum += 8'(8'hA0 + i);
      repeat (3) tick();
    end
    wait_done(db, 200, ok);
    tick();
    n_cmp += 4;
    if (!ok) begin n_err++; $display("FAIL starved_timeout got no done want done"); end
    if (empty_pops != ep) begin n_err++; $display("FAIL starved_pop_while_empty got %0d want 0", empty_pops - ep); end
    if (pop_cyc_q.size() - pb != 16)
      begin n_err++; $display("FAIL starved_pops got %0d want 16", pop_cyc_q.size() - pb); end
    if (checksum !== sum) begin n_err++; $display("FAIL starved_checksum got %h want %h", checksum, sum); end
    n_cmp++;
    if (got_q.size() - gb != 16) begin n_err++; $display("FAIL starved_count got %0d want 16", got_q.size() - gb); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      a = (gb + i < got_q.size()) ? got_q[gb+i] : 'x;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL starved_data[%0d] got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_backpressure();
    int gb, db, se, k;
    bit ok;
    bit pat [4];
    logic [DSIZE-1:0] sum, e, a;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_q.delete();
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      wr_log.push_back(8'(8'h30 + 3 * i));
      exp_q.push_back(8'(8'h30 + 3 * i));
      sum += 8'(8'h30 + 3 * i);
    end
    tick(); tick();
    gb = got_q.size(); db = done_cyc_q.size(); se = stab_err;
    start = 1'b1; tick(); start = 1'b0;
    ok = 1'b0;
    k = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      out_ready = pat[k % 4];
      k++;
      tick();
      ok = (done_cyc_q.size() > db);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    n_cmp += 5;
    if (!ok) begin n_err++; $display("FAIL bp_timeout got no done want done"); end
    if (stab_err != se) begin n_err++; $display("FAIL bp_stable got %0d violations want 0", stab_err - se); end
    if (got_q.size() - gb != 16) begin n_err++; $display("FAIL bp_accepts got %0d want 16", got_q.size() - gb); end
    if (done_cyc_q.size() != db + 1 || acc_cyc_q.size() == 0 || done_cyc_q[db] != acc_cyc_q[acc_cyc_q.size()-1] + 1)
      begin n_err++; $display("FAIL bp_done_after_last got %0d want %0d", (done_cyc_q.size() > db) ? done_cyc_q[db] : -1, acc_cyc_q[acc_cyc_q.size()-1] + 1); end
    if (checksum !== sum) begin n_err++; $display("FAIL bp_checksum got %h want %h", checksum, sum); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      a = (gb + i < got_q.size()) ? got_q[gb+i] : 'x;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL bp_data[%0d] got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_wrap();
    int gb, db;
    bit ok;
    int ff_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr_log.push_back(8'hFF);
    tick(); tick();
    gb = got_q.size(); db = done_cyc_q.size();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(db, 200, ok);
    tick();
    ff_cnt = 0;
    for (int i = gb; i < got_q.size(); i++) if (got_q[i] === 8'hFF) ff_cnt++;
    n_cmp += 3;
    if (!ok) begin n_err++; $display("FAIL wrap_timeout got no done want done"); end
    if (checksum !== 8'hF0) begin n_err++; $display("FAIL wrap_checksum got %h want f0", checksum); end
    if (ff_cnt != 16) begin n_err++; $display("FAIL wrap_data got %0d words of ff want 16", ff_cnt); end
  endtask

  task automatic test_ignored_start();
    int pb, gb, db;
    bit ok;
    logic [DSIZE-1:0] e, a;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_log.push_back(8'(8'h60 + i));
      exp_q.push_back(8'(8'h60 + i));
    end
    tick(); tick();
    pb = pop_cyc_q.size(); gb = got_q.size(); db = done_cyc_q.size();
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    // FIFO now drained to empty mid-FILL; poke start while stalled.
    for (int i = 0; i < 3; i++) begin start = 1'b1; tick(); start = 1'b0; tick(); end
    for (int i = 8; i < 16; i++) begin
      wr_log.push_back(8'(8'h60 + i));
      exp_q.push_back(8'(8'h60 + i));
    end
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    for (int i = 0; i < 3; i++) begin start = 1'b1; tick(); start = 1'b0; tick(); end
    out_ready = 1'b1;
    wait_done(db, 200, ok);
    repeat (50) tick();
    n_cmp += 5;
    if (!ok) begin n_err++; $display("FAIL ign_timeout got no done want done"); end
    if (done_cyc_q.size() - db != 1) begin n_err++; $display("FAIL ign_done_count got %0d want 1", done_cyc_q.size() - db); end
    if (pop_cyc_q.size() - pb != 16) begin n_err++; $display("FAIL ign_pops got %0d want 16", pop_cyc_q.size() - pb); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL ign_busy_after got %b want 0", busy); end
    if (got_q.size() - gb != 16) begin n_err++; $display("FAIL ign_accepts got %0d want 16", got_q.size() - gb); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      a = (gb + i < got_q.size()) ? got_q[gb+i] : 'x;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL ign_data[%0d] got %h want %h", i, a, e); end
    end
  endtask

  task automatic test_reset_mid();
    int pb, gb, db;
    bit ok;
    logic [DSIZE-1:0] sum, e, a;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_log.push_back(8'(8'h50 + i));
      exp_q.push_back(8'(8'h50 + i));
    end
    tick(); tick();
    pb = pop_cyc_q.size();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 50 && pop_cyc_q.size() - pb < 5; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp += 7;
    if (pop_cyc_q.size() - pb != 5) begin n_err++; $display("FAIL rm_pops_before got %0d want 5", pop_cyc_q.size() - pb); end
    if (rinc !== 1'b0) begin n_err++; $display("FAIL rm_rinc got %b want 0", rinc); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got %b want 0", busy); end
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid got %b want 0", out_valid); end
    if (done !== 1'b0) begin n_err++; $display("FAIL rm_done got %b want 0", done); end
    if (checksum !== 8'h00) begin n_err++; $display("FAIL rm_checksum got %h want 00", checksum); end
    if (out_data !== 8'h00) begin n_err++; $display("FAIL rm_out_data got %h want 00", out_data); end
    tick(); tick();
    n_cmp++;
    if (fifo_q.size() != 11) begin n_err++; $display("FAIL rm_fifo_left got %0d want 11", fifo_q.size()); end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      wr_log.push_back(8'(8'h70 + i));
      exp_q.push_back(8'(8'h70 + i));
    end
    sum = '0;
    foreach (exp_q[i]) sum += exp_q[i];
    tick(); tick();
    gb = got_q.size(); db = done_cyc_q.size();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(db, 200, ok);
    tick();
    n_cmp += 3;
    if (!ok) begin n_err++; $display("FAIL rm_timeout got no done want done"); end
    if (checksum !== sum) begin n_err++; $display("FAIL rm_checksum_after got %h want %h", checksum, sum); end
    if (fifo_q.size() != 0) begin n_err++; $display("FAIL rm_fifo_after got %0d want 0", fifo_q.size()); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      a = (gb + i < got_q.size()) ? got_q[gb+i] : 'x;
      n_cmp++;
      if (a !== e) begin n_err++; $display("FAIL rm_data[%0d] got %h want %h", i, a, e); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_starved();
    test_backpressure();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    n_cmp++;
    if (empty_pops != 0) begin n_err++; $display("FAIL global_pop_while_empty got %0d want 0", empty_pops); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
